// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: two-flop synchroniser feeding an independent filter
// FSM per channel, with press/release strobes, long-press and auto-repeat.
module key_debounce_multi #(
  parameter int KEY_W      = 3,
  parameter int T_FILTER   = 1_000_000,
  parameter int T_LONG     = 50_000_000,
  parameter int T_REPEAT   = 10_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_level,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_repeat
);

  localparam int FW   = (T_FILTER > 1) ? $clog2(T_FILTER) : 1;
  localparam int HMAX = (T_LONG > T_REPEAT) ? T_LONG : T_REPEAT;
  localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;
  localparam bit LONG_EN = (T_LONG > 0);
  localparam bit REP_EN  = (T_LONG > 0) && (T_REPEAT > 0);
  localparam logic [FW-1:0] F_END = FW'(T_FILTER - 1);
  localparam logic [HW-1:0] L_END = LONG_EN ? HW'(T_LONG - 1) : {HW{1'b0}};
  localparam logic [HW-1:0] R_END = REP_EN ? HW'(T_REPEAT - 1) : {HW{1'b0}};
  // Synchroniser resets to the released level so reset never looks like a press
  localparam logic [KEY_W-1:0] IDLE_LVL = ACTIVE_LOW ? {KEY_W{1'b1}} : {KEY_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_FILTER_DOWN = 2'd1,
    ST_HOLD_DOWN   = 2'd2,
    ST_FILTER_UP   = 2'd3
  } state_t;

  logic [KEY_W-1:0] sync1_r;
  logic [KEY_W-1:0] sync2_r;
  logic [KEY_W-1:0] pressed_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= IDLE_LVL;
      sync2_r <= IDLE_LVL;
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
    end
  end

  assign pressed_s = ACTIVE_LOW ? ~sync2_r : sync2_r;

  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    state_t        state_r, state_s;
    logic [FW-1:0] fcnt_r, fcnt_s;
    logic [HW-1:0] hcnt_r, hcnt_s;
    logic          rep_ph_r, rep_ph_s;
    logic          level_r, level_s;
    logic          press_r, press_s;
    logic          release_r, release_s;
    logic          long_r, long_s;
    logic          repeat_r, repeat_s;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r   <= ST_IDLE;
        fcnt_r    <= {FW{1'b0}};
        hcnt_r    <= {HW{1'b0}};
        rep_ph_r  <= 1'b0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        state_r   <= state_s;
        fcnt_r    <= fcnt_s;
        hcnt_r    <= hcnt_s;
        rep_ph_r  <= rep_ph_s;
        level_r   <= level_s;
        press_r   <= press_s;
        release_r <= release_s;
        long_r    <= long_s;
        repeat_r  <= repeat_s;
      end
    end

    always_comb begin
      state_s   = state_r;
      fcnt_s    = fcnt_r;
      hcnt_s    = hcnt_r;
      rep_ph_s  = rep_ph_r;
      level_s   = level_r;
      press_s   = 1'b0;
      release_s = 1'b0;
      long_s    = 1'b0;
      repeat_s  = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pressed_s[i]) begin
            state_s = ST_FILTER_DOWN;
            fcnt_s  = {FW{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FILTER_DOWN: begin
          if (!pressed_s[i]) begin
            state_s = ST_IDLE;
          end else if (fcnt_r == F_END) begin
            state_s  = ST_HOLD_DOWN;
            press_s  = 1'b1;
            level_s  = 1'b1;
            hcnt_s   = {HW{1'b0}};
            rep_ph_s = 1'b0;
          end else begin
            fcnt_s = fcnt_r + FW'(1'b1);
          end
        end
        ST_HOLD_DOWN: begin
          // Release takes priority; the hold count stays put while filtering up
          if (!pressed_s[i]) begin
            state_s = ST_FILTER_UP;
            fcnt_s  = {FW{1'b0}};
          end else if (!rep_ph_r) begin
            if (LONG_EN && (hcnt_r == L_END)) begin
              long_s   = 1'b1;
              hcnt_s   = {HW{1'b0}};
              rep_ph_s = 1'b1;
            end else if (LONG_EN) begin
              hcnt_s = hcnt_r + HW'(1'b1);
            end else begin
              hcnt_s = hcnt_r;
            end
          end else begin
            if (REP_EN && (hcnt_r == R_END)) begin
              repeat_s = 1'b1;
              hcnt_s   = {HW{1'b0}};
            end else if (REP_EN) begin
              hcnt_s = hcnt_r + HW'(1'b1);
            end else begin
              hcnt_s = hcnt_r;
            end
          end
        end
        ST_FILTER_UP: begin
          if (pressed_s[i]) begin
            state_s = ST_HOLD_DOWN;
          end else if (fcnt_r == F_END) begin
            state_s   = ST_IDLE;
            release_s = 1'b1;
            level_s   = 1'b0;
            hcnt_s    = {HW{1'b0}};
            rep_ph_s  = 1'b0;
          end else begin
            fcnt_s = fcnt_r + FW'(1'b1);
          end
        end
        default: begin
          state_s  = ST_IDLE;
          fcnt_s   = {FW{1'b0}};
          hcnt_s   = {HW{1'b0}};
          rep_ph_s = 1'b0;
          level_s  = 1'b0;
        end
      endcase
    end

    assign key_level[i]   = level_r;
    assign key_press[i]   = press_r;
    assign key_release[i] = release_r;
    assign key_long[i]    = long_r;
    assign key_repeat[i]  = repeat_r;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: each scenario drives key_in after
// "edge 0" and compares all outputs after every following edge.
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_in;
  logic [2:0] key_level, key_press, key_release, key_long, key_repeat;
  logic [14:0] obs_s;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .KEY_W(3), .T_FILTER(8), .T_LONG(40), .T_REPEAT(10), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat)
  );

  assign obs_s = {key_level, key_press, key_release, key_long, key_repeat};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] win(input int e, input int a, input int b, input logic [2:0] v);
    return (e >= a && e <= b) ? v : 3'b000;
  endfunction

  function automatic logic [14:0] ex(input logic [2:0] lv, input logic [2:0] pr,
                                     input logic [2:0] rl, input logic [2:0] lg,
                                     input logic [2:0] rp);
    return {lv, pr, rl, lg, rp};
  endfunction

  initial begin
    rst    = 1'b1;
    key_in = 3'b111;
    repeat (3) step();
    check_eq("reset", obs_s, 15'h0);
    rst = 1'b0;
    repeat (5) step();
    check_eq("idle", obs_s, 15'h0);

    // 1: clean press/release on channel 0, too short for long press
    key_in = 3'b110;
    for (int e = 1; e <= 60; e++) begin
      step();
      check_eq($sformatf("s1 e%0d", e), obs_s,
               ex(win(e, 11, 40, 3'b001), win(e, 11, 11, 3'b001), win(e, 41, 41, 3'b001),
                  3'b000, 3'b000));
      if (e == 30) key_in = 3'b111;
    end

    // 2: 5-cycle bounce on channel 1 is rejected
    key_in = 3'b101;
    for (int e = 1; e <= 30; e++) begin
      step();
      check_eq($sformatf("s2 e%0d", e), obs_s, 15'h0);
      if (e == 5) key_in = 3'b111;
    end

    // 3: long press with auto-repeat on channel 2
    key_in = 3'b011;
    for (int e = 1; e <= 115; e++) begin
      step();
      check_eq($sformatf("s3 e%0d", e), obs_s,
               ex(win(e, 11, 105, 3'b100), win(e, 11, 11, 3'b100), win(e, 106, 106, 3'b100),
                  win(e, 51, 51, 3'b100),
                  (e >= 61 && e <= 91 && (e - 61) % 10 == 0) ? 3'b100 : 3'b000));
      if (e == 95) key_in = 3'b111;
    end

    // 4: 3-cycle release glitch mid-hold is filtered out
    key_in = 3'b110;
    for (int e = 1; e <= 60; e++) begin
      step();
      check_eq($sformatf("s4 e%0d", e), obs_s,
               ex(win(e, 11, 50, 3'b001), win(e, 11, 11, 3'b001), win(e, 51, 51, 3'b001),
                  3'b000, 3'b000));
      if (e == 20) key_in = 3'b111;
      if (e == 23) key_in = 3'b110;
      if (e == 40) key_in = 3'b111;
    end

    // 5: reset while held clears at once, then a fresh press follows
    key_in = 3'b110;
    for (int e = 1; e <= 20; e++) begin
      step();
      check_eq($sformatf("s5a e%0d", e), obs_s,
               ex(win(e, 11, 20, 3'b001), win(e, 11, 11, 3'b001), 3'b000, 3'b000, 3'b000));
    end
    rst = 1'b1;
    #2;
    check_eq("s5 async clear", obs_s, 15'h0);
    step();
    check_eq("s5 in reset 1", obs_s, 15'h0);
    step();
    check_eq("s5 in reset 2", obs_s, 15'h0);
    rst = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      step();
      check_eq($sformatf("s5b e%0d", e), obs_s,
               ex(win(e, 11, 25, 3'b001), win(e, 11, 11, 3'b001), win(e, 26, 26, 3'b001),
                  3'b000, 3'b000));
      if (e == 15) key_in = 3'b111;
    end

    // 6: channels 0 and 2 together
    key_in = 3'b010;
    for (int e = 1; e <= 40; e++) begin
      step();
      check_eq($sformatf("s6 e%0d", e), obs_s,
               ex(win(e, 11, 30, 3'b101), win(e, 11, 11, 3'b101), win(e, 31, 31, 3'b101),
                  3'b000, 3'b000));
      if (e == 20) key_in = 3'b111;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel key debouncer; successor to the fixed 3-key debounce FSM.
- Each channel runs its own four-state filter FSM with a private counter; channels do not share timing.
- Adds selectable active level, single-cycle press/release strobes, long-press detection and auto-repeat.
- Sits between raw board pushbuttons and user control logic (menus, counters, mode selects).

Parameters:
- KEY_W, 3, number of independent key channels.
- T_FILTER, 1_000_000, debounce window in clk cycles (20 ms at 50 MHz); legal range >= 2.
- T_LONG, 50_000_000, cycles from key_press to key_long; 0 disables long press and repeat.
- T_REPEAT, 10_000_000, auto-repeat period after key_long; 0 disables repeat.
- ACTIVE_LOW, 1, 1 = pressed key reads 0; 0 = pressed key reads 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_in  in  KEY_W  raw asynchronous key inputs.
- key_level  out  KEY_W  debounced state per channel; 1 = pressed.
- key_press  out  KEY_W  1-cycle strobe per channel on an accepted press.
- key_release  out  KEY_W  1-cycle strobe per channel on an accepted release.
- key_long  out  KEY_W  1-cycle strobe per channel, once per press, after T_LONG.
- key_repeat  out  KEY_W  1-cycle strobe per channel every T_REPEAT after key_long while held.

Behaviour:
- Reset is asynchronous, active-high.
  - All outputs 0; all FSMs IDLE; all counters 0.
  - Synchroniser flops reset to the inactive level (all 1s when ACTIVE_LOW=1), so reset produces no spurious press.
- Synchroniser: 2 flops per bit. pressed[i] = sync bit equals the active level.
- Per-channel FSM:
  - Filter counter fcnt, width clog2(T_FILTER).
  - Hold counter hcnt, width clog2(max(T_LONG,T_REPEAT)+1).
- IDLE: pressed -> FILTER_DOWN, fcnt=0.
- FILTER_DOWN:
  - !pressed -> IDLE, no outputs (bounce rejected).
  - pressed and fcnt==T_FILTER-1 -> HOLD_DOWN; key_press pulses 1 cycle; key_level<=1; hcnt=0.
  - Otherwise fcnt++.
- HOLD_DOWN:
  - hcnt increments each cycle.
  - At hcnt==T_LONG-1: key_long pulses 1 cycle, once; hcnt reloads 0 and enters repeat phase.
  - In repeat phase, at hcnt==T_REPEAT-1: key_repeat pulses 1 cycle; hcnt reloads 0.
  - !pressed -> FILTER_UP, fcnt=0.
- FILTER_UP:
  - hcnt frozen.
  - pressed -> HOLD_DOWN; no new key_press; hold timing resumes.
  - !pressed and fcnt==T_FILTER-1 -> IDLE; key_release pulses 1 cycle; key_level<=0; hcnt and repeat phase cleared.
- Latency: key_in change registered at edge 0 -> sync visible after edge 2 -> FSM leaves IDLE at edge 3 -> key_press high for the cycle after edge 3+T_FILTER. Release is symmetric.
- key_long asserts exactly T_LONG cycles after key_press; the k-th key_repeat asserts T_LONG + k*T_REPEAT cycles after key_press. This holds only if no FILTER_UP excursion occurs, since hcnt freezes during FILTER_UP.
- Disables: T_LONG==0 -> key_long and key_repeat stay 0. T_REPEAT==0 -> key_repeat stays 0.
- Channels are fully independent. Simultaneous events on several channels assert the corresponding bits in the same cycle.
- key_press and key_long never coincide on one channel (T_LONG >= 1 after press).
- key_long and key_repeat are mutually exclusive on one channel.
- Reset asserted mid-operation clears immediately; no key_release is emitted. A key still held after reset deasserts produces a fresh press after T_FILTER+3 cycles.

Test Plan:
Common setup: KEY_W=3, T_FILTER=8, T_LONG=40, T_REPEAT=10, ACTIVE_LOW=1.
1. key_in[0] low 30 cycles then high -> key_press=3'b001 for 1 cycle at edge 11; key_level[0]=1 from edge 11; key_release[0] 1 cycle 11 edges after the rising edge; key_long stays 0.
2. key_in[1] low 5 cycles then high (bounce) -> no strobes on any output; key_level stays 3'b000.
3. key_in[2] low 95 cycles -> key_press[2] at edge 11; key_long[2] at 51; key_repeat[2] at 61, 71, 81, 91 (exactly 4); key_release[2] near edge 106.
4. key_in[0] held, then 3-cycle high glitch mid-hold -> no key_release; no second key_press; key_level[0] stays 1 throughout.
5. rst pulsed while key_in[0] held and key_level[0]=1 -> all outputs 0 asynchronously, no key_release; after rst falls, key_press[0] 11 cycles later.
6. key_in[0] and key_in[2] fall in the same cycle -> key_press=3'b101 in one cycle; later releases in the same cycle -> key_release=3'b101.
